// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the mult/div sequencer: funct codes, bus types,
// sequencer state encoding and sign-fix helpers.
package mult_div_ctrl_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FUNCT_W = 6;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [2*DATA_W-1:0] ddata_t;
  typedef logic [FUNCT_W-1:0]  funct_t;

  localparam funct_t FUNCT_MULT  = 6'b011000;
  localparam funct_t FUNCT_MULTU = 6'b011001;
  localparam funct_t FUNCT_DIV   = 6'b011010;
  localparam funct_t FUNCT_DIVU  = 6'b011011;

  localparam data_t DIV_ZERO_Q = '1;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2,
    MD_DONE = 2'd3
  } md_state_e;

  function automatic logic is_md_funct(funct_t f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  function automatic data_t cond_neg(logic neg, data_t v);
    return neg ? (~v + data_t'(1)) : v;
  endfunction

  function automatic ddata_t cond_neg_d(logic neg, ddata_t v);
    return neg ? (~v + ddata_t'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_div_ctrl_if.sv
// EX-stage <-> mult/div sequencer handshake: operation request, flush,
// pipeline hold and 64-bit {hi,lo} result.
interface mult_div_ctrl_if;
  import mult_div_ctrl_pkg::*;

  logic   flush;
  logic   start;
  funct_t funct;
  data_t  operand_1;
  data_t  operand_2;
  logic   stall_req;
  logic   mult_div_done;
  ddata_t mult_div_result;
  logic   busy;

  modport master (
    output flush, start, funct, operand_1, operand_2,
    input  stall_req, mult_div_done, mult_div_result, busy
  );

  modport slave (
    input  flush, start, funct, operand_1, operand_2,
    output stall_req, mult_div_done, mult_div_result, busy
  );

endinterface

// File: rtl/mult_div_ctrl_div_core.sv
// One restoring-division iteration per i_step on unsigned magnitudes;
// exposes the post-step quotient/remainder so the caller can finish on the last step.
module mult_div_ctrl_div_core
  import mult_div_ctrl_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_load,
  input  logic  i_step,
  input  data_t i_dividend,
  input  data_t i_divisor,
  output data_t o_quot_nxt,
  output data_t o_rem_nxt
);

  data_t r_rem;
  data_t r_quot;
  data_t r_dvs;

  logic [DATA_W:0] w_shift;
  logic            w_ge;

  always_comb begin
    w_shift    = {r_rem, r_quot[DATA_W-1]};
    w_ge       = w_shift >= {1'b0, r_dvs};
    // Difference is always below the divisor, so 32-bit wraparound is exact.
    o_rem_nxt  = w_ge ? (w_shift[DATA_W-1:0] - r_dvs) : w_shift[DATA_W-1:0];
    o_quot_nxt = {r_quot[DATA_W-2:0], w_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dvs  <= '0;
    end else if (i_load) begin
      r_rem  <= '0;
      r_quot <= i_dividend;
      r_dvs  <= i_divisor;
    end else if (i_step) begin
      r_rem  <= o_rem_nxt;
      r_quot <= o_quot_nxt;
    end
  end

endmodule

// File: rtl/mult_div_ctrl.sv
// MULT/MULTU/DIV/DIVU sequencer holding the pipeline until {hi,lo} is ready.
// Define MULT_ITER_EN for a 32-cycle shift-add multiplier; default is single-cycle.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32,
  parameter int unsigned CNT_W      = 6
) (
  input  logic           clk,
  input  logic           rst,
  mult_div_ctrl_if.slave md
);

  md_state_e        r_state;
  md_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  ddata_t           r_result;
  logic             r_qneg;
  logic             r_rneg;

  logic  w_accept, w_is_div, w_signed, w_div_zero, w_last, w_running;
  logic  w_s1, w_s2, w_stall, w_done;
  data_t w_abs1, w_abs2, w_quot_nxt, w_rem_nxt;

`ifdef MULT_ITER_EN
  ddata_t r_prod;
  ddata_t r_mcand;
  data_t  r_mplier;
  ddata_t w_prod_nxt;

  always_comb w_prod_nxt = r_prod + (r_mplier[0] ? r_mcand : '0);
`endif

  always_comb begin
    w_is_div   = (md.funct == FUNCT_DIV) || (md.funct == FUNCT_DIVU);
    w_signed   = (md.funct == FUNCT_DIV) || (md.funct == FUNCT_MULT);
    w_s1       = w_signed & md.operand_1[DATA_W-1];
    w_s2       = w_signed & md.operand_2[DATA_W-1];
    w_abs1     = cond_neg(w_s1, md.operand_1);
    w_abs2     = cond_neg(w_s2, md.operand_2);
    w_div_zero = w_is_div && (md.operand_2 == '0);
    w_accept   = md.start && is_md_funct(md.funct) && (r_state == MD_IDLE) && !md.flush;
    w_running  = ((r_state == MD_MUL) || (r_state == MD_DIV)) && !md.flush;
    w_last     = r_cnt == CNT_W'(DIV_CYCLES - 1);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      MD_IDLE: begin
        if (w_accept) begin
          w_stall = 1'b1;
          if (w_is_div)
            w_state_nxt = w_div_zero ? MD_DONE : MD_DIV;
          else
`ifdef MULT_ITER_EN
            w_state_nxt = MD_MUL;
`else
            w_state_nxt = MD_DONE;
`endif
        end
      end
      MD_MUL, MD_DIV: begin
        w_stall = 1'b1;
        if (w_last) w_state_nxt = MD_DONE;
      end
      MD_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = MD_IDLE;
      end
      default: w_state_nxt = MD_IDLE;
    endcase
    // Flush overrides everything, including the done pulse of the current cycle.
    if (md.flush) begin
      w_state_nxt = MD_IDLE;
      w_stall     = 1'b0;
      w_done      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_qneg   <= 1'b0;
      r_rneg   <= 1'b0;
`ifdef MULT_ITER_EN
      r_prod   <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
`endif
    end else if (w_accept) begin
      r_cnt  <= '0;
      r_qneg <= w_s1 ^ w_s2;
      r_rneg <= w_s1;
      if (w_div_zero)
        r_result <= {md.operand_1, DIV_ZERO_Q};
`ifdef MULT_ITER_EN
      r_prod   <= '0;
      r_mcand  <= ddata_t'(w_abs1);
      r_mplier <= w_abs2;
`else
      else if (!w_is_div)
        r_result <= cond_neg_d(w_s1 ^ w_s2, ddata_t'(w_abs1) * ddata_t'(w_abs2));
`endif
    end else if (w_running) begin
      r_cnt <= r_cnt + CNT_W'(1);
`ifdef MULT_ITER_EN
      if (r_state == MD_MUL) begin
        r_prod   <= w_prod_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
      end
      if (w_last && (r_state == MD_MUL))
        r_result <= cond_neg_d(r_qneg, w_prod_nxt);
      else
`endif
      if (w_last)
        r_result <= {cond_neg(r_rneg, w_rem_nxt), cond_neg(r_qneg, w_quot_nxt)};
    end
  end

  mult_div_ctrl_div_core u_div_core (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_accept && w_is_div),
    .i_step     (w_running && (r_state == MD_DIV)),
    .i_dividend (w_abs1),
    .i_divisor  (w_abs2),
    .o_quot_nxt (w_quot_nxt),
    .o_rem_nxt  (w_rem_nxt)
  );

  assign md.stall_req       = w_stall;
  assign md.mult_div_done   = w_done;
  assign md.mult_div_result = r_result;
  assign md.busy            = r_state != MD_IDLE;

endmodule

// File: doc/mult_div_ctrl.md
Name: mult_div_ctrl

Overview:
- Multi-cycle sequencer for MULT/MULTU/DIV/DIVU in the EX stage.
- Accepts an operation from EX, runs an iterative radix-2 divider or a multiplier, and holds the pipeline via stall_req.
- Delivers the 64-bit {hi,lo} result with a one-cycle done pulse; the HILO write-back logic commits it to HI/LO on that pulse.

Parameters:
- DIV_CYCLES, 32, number of quotient iterations; must equal data width.
- CNT_W, 6, width of the iteration counter; must satisfy 2^CNT_W > DIV_CYCLES.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- flush  input  1  cancel in-flight operation (exception/branch flush)
- start  input  1  EX holds a valid mult/div instruction
- funct  input  `FUNCT_BUS  function code; only FUNCT_MULT/MULTU/DIV/DIVU act
- operand_1  input  `DATA_BUS  rs: multiplicand / dividend
- operand_2  input  `DATA_BUS  rt: multiplier / divisor
- stall_req  output  1  hold IF/ID/EX this cycle
- mult_div_done  output  1  one-cycle pulse: result valid
- mult_div_result  output  `DOUBLE_DATA_BUS  {hi,lo}; DIV: hi = remainder, lo = quotient
- busy  output  1  state is not IDLE

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset state: IDLE. stall_req=0, mult_div_done=0, mult_div_result=0, busy=0, counter=0.
- States: IDLE, MUL, DIV, DONE.
- Accept condition: start & valid funct & state==IDLE & !flush. In the accept cycle stall_req=1 (combinational), and operands are latched.
- Signed ops (MULT, DIV): latch absolute values plus sign flags. Unsigned ops: zero-extend. Sign fix is applied when entering DONE.
  - Quotient sign = s1 ^ s2.
  - Remainder sign = s1.
  - 0x80000000 / -1: quotient 0x80000000, remainder 0 (natural wrap).
- DIV:
  - 32 restoring iterations, counter 0..31; one quotient bit per cycle.
  - After counter==31, go to DONE.
  - Accept at cycle T -> mult_div_done at T+33.
- Divide by zero:
  - Skip iterations; accept -> DONE directly.
  - Result: lo=0xFFFFFFFF, hi=operand_1 (raw dividend). done at T+1.
- MUL: see Optional Feature.
- stall_req:
  - 1 in the accept cycle and in MUL/DIV states.
  - 0 in DONE, so EX advances in the same cycle the done pulse is seen.
- DONE: mult_div_done=1 for exactly one cycle, start is ignored, next state is IDLE.
- Back-to-back: the next mult/div instruction reaches EX one cycle after DONE, finds IDLE, and is accepted.
- mult_div_result holds its value until the next DONE; it is not cleared in IDLE.
- flush:
  - In any state: next state IDLE, no done pulse, stall_req=0 in the flush cycle.
  - flush has priority over start in the same cycle.
- rst mid-operation: immediate return to reset state on the next edge; no done pulse.
- Non-mult/div funct with start=1: ignored, stall_req=0.

Optional Feature:
- Macro: MULT_ITER_EN.
- Defined:
  - MUL is a 32-cycle shift-add loop reusing the counter.
  - Accept T -> done at T+33; stall as for DIV.
- Undefined:
  - Product is computed in the accept cycle (single-cycle multiplier) and registered.
  - State goes to DONE directly; done at T+1. The MUL state is unreachable.

Decomposition:
- Shared header (funct.v/bus.v family):
  - FUNCT_MULT/MULTU/DIV/DIVU codes.
  - Mult/div state encoding constants.
  - DIV_ZERO_Q constant (0xFFFFFFFF).
- Sub-module div_core:
  - Holds one iteration of restoring division: partial remainder, quotient shift, compare/subtract.
  - Instantiated once; the controller owns the counter and FSM.

Test Plan:
- DIVU 100/7: start at T -> stall_req 1 for T..T+32, done at T+33 with hi=2, lo=14.
- DIV -7/2: result hi=0xFFFFFFFF (-1), lo=0xFFFFFFFD (-3).
- DIV 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
- DIV 5/0: done at T+1, lo=0xFFFFFFFF, hi=5.
- MULT 0xFFFFFFFF*2:
  - Without MULT_ITER_EN: done at T+1, result 0xFFFFFFFF_FFFFFFFE.
  - With MULT_ITER_EN: same result at T+33.
- MULTU 0xFFFFFFFF*2: result 0x00000001_FFFFFFFE.
- flush at iteration 10 of DIVU: no done pulse, IDLE next cycle, stall_req=0; a new DIVU 9/3 issued the following cycle gives hi=0, lo=3.
- rst at iteration 10: outputs return to reset values on the next edge.
- Back-to-back DIVU then MULTU with start held high through done: each executes exactly once and produces two done pulses.
